// File: rtl/shift_counter_pkg.sv
// Shared definitions for the shift-register counter: mode encodings, operation
// selector and the reset-pattern helper used by the RTL and the bench.
package shift_counter_pkg;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;

  // Widest counter the reset-pattern helper can describe.
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_STEP,
    OP_LOAD,
    OP_INIT
  } op_e;

  // Ring sequences start from a single set LSB; Johnson sequences from all zeros.
  function automatic logic [MAX_W-1:0] reset_pattern(input logic mode, input int n);
    logic [MAX_W-1:0] pat;
    pat = '0;
    if (mode == MODE_RING && n > 0) begin
      pat[0] = 1'b1;
    end
    return pat;
  endfunction

endpackage

// File: rtl/shift_counter_if.sv
// Control and status bundle of the shift-register counter; the driver uses
// the master view, the counter itself the slave view.
interface shift_counter_if #(
  parameter int N = 4
);
  localparam int PW = $clog2(2 * N);

  logic          en;
  logic          left;
  logic          mode;
  logic          load;
  logic [N-1:0]  load_val;
  logic [N-1:0]  q;
  logic [PW-1:0] phase;
  logic          wrap;
  logic          err;

  modport master (
    output en,
    output left,
    output mode,
    output load,
    output load_val,
    input  q,
    input  phase,
    input  wrap,
    input  err
  );

  modport slave (
    input  en,
    input  left,
    input  mode,
    input  load,
    input  load_val,
    output q,
    output phase,
    output wrap,
    output err
  );

endinterface

// File: rtl/shift_counter_decode.sv
// Combinational legality check and phase decode of a counter value for a
// given mode (ring one-hot or Johnson twisted-ring).
module shift_counter_decode
  import shift_counter_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = $clog2(2 * N)
) (
  input  logic [N-1:0]  value,
  input  logic          mode,
  output logic          legal,
  output logic [PW-1:0] phase
);

  logic [N-1:0]  value_inv;
  logic          low_run;
  logic          high_run;
  logic [PW-1:0] pop_cnt;
  logic [PW-1:0] ring_idx;
  logic          ring_legal;
  logic          john_legal;
  logic [PW-1:0] john_phase;

  assign value_inv = ~value;

  // A run of ones anchored at bit 0 has no carry overlap with itself plus one;
  // the same test on the inverse finds runs anchored at the MSB.
  assign low_run  = ((value & (value + N'(1))) == '0);
  assign high_run = ((value_inv & (value_inv + N'(1))) == '0);

  always_comb begin
    pop_cnt  = '0;
    ring_idx = '0;
    for (int i = 0; i < N; i++) begin
      pop_cnt = pop_cnt + PW'(value[i]);
      if (value[i]) begin
        ring_idx = PW'(i);
      end
    end
  end

  assign ring_legal = (pop_cnt == PW'(1));
  assign john_legal = low_run || high_run;

  always_comb begin
    john_phase = '0;
    if (value == '0) begin
      john_phase = '0;
    end else if (value[0]) begin
      john_phase = pop_cnt;
    end else begin
      john_phase = PW'(2 * N) - pop_cnt;
    end
  end

  always_comb begin
    legal = 1'b0;
    phase = '0;
    if (mode == MODE_JOHNSON) begin
      legal = john_legal;
      phase = john_phase;
    end else begin
      legal = ring_legal;
      phase = ring_idx;
    end
  end

endmodule

// File: rtl/shift_counter.sv
// N-bit ring/Johnson shift counter with bidirectional stepping, checked
// parallel load, phase tracking, wrap pulse and sticky illegal-load flag.
module shift_counter
  import shift_counter_pkg::*;
#(
  parameter int N            = 4,
  parameter bit SELF_CORRECT = 1'b1
) (
  input  logic            clk,
  input  logic            init,
  shift_counter_if.slave  bus
);

  localparam int PW = $clog2(2 * N);
  localparam logic [PW-1:0] RING_LAST = PW'(N - 1);
  localparam logic [PW-1:0] JOHN_LAST = PW'(2 * N - 1);

  logic          mode_q, mode_d;
  logic [N-1:0]  state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          wrap_q, wrap_d;
  logic          err_q, err_d;

  op_e           op;
  logic [N-1:0]  init_pat;
  logic [N-1:0]  load_pat;
  logic          load_legal;
  logic [PW-1:0] load_phase;
  logic [N-1:0]  step_val;
  logic [PW-1:0] phase_last;
  logic [PW-1:0] phase_step;

  shift_counter_decode #(
    .N  (N),
    .PW (PW)
  ) u_decode (
    .value (bus.load_val),
    .mode  (bus.mode),
    .legal (load_legal),
    .phase (load_phase)
  );

  assign init_pat = N'(reset_pattern(bus.mode, N));
  assign load_pat = N'(reset_pattern(bus.mode, N));

  always_comb begin
    if (init) begin
      op = OP_INIT;
    end else if (bus.load) begin
      op = OP_LOAD;
    end else if (bus.en) begin
      op = OP_STEP;
    end else begin
      op = OP_HOLD;
    end
  end

  // Johnson differs from ring only by inverting the bit that re-enters.
  always_comb begin
    if (bus.left) begin
      step_val = {state_q[N-2:0], state_q[N-1] ^ mode_q};
    end else begin
      step_val = {state_q[0] ^ mode_q, state_q[N-1:1]};
    end
  end

  assign phase_last = (mode_q == MODE_JOHNSON) ? JOHN_LAST : RING_LAST;

  always_comb begin
    if (bus.left) begin
      phase_step = (phase_q >= phase_last) ? '0 : phase_q + PW'(1);
    end else begin
      phase_step = (phase_q == '0) ? phase_last : phase_q - PW'(1);
    end
  end

  always_comb begin
    mode_d  = mode_q;
    state_d = state_q;
    phase_d = phase_q;
    wrap_d  = 1'b0;
    err_d   = err_q;
    unique case (op)
      OP_LOAD: begin
        mode_d = bus.mode;
        if (load_legal) begin
          state_d = bus.load_val;
          phase_d = load_phase;
        end else begin
          state_d = SELF_CORRECT ? load_pat : bus.load_val;
          phase_d = '0;
          err_d   = 1'b1;
        end
      end
      OP_STEP: begin
        state_d = step_val;
        phase_d = phase_step;
        wrap_d  = (phase_step == '0);
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (init) begin
      mode_q  <= bus.mode;
      state_q <= init_pat;
      phase_q <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      state_q <= state_d;
      phase_q <= phase_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign bus.q     = state_q;
  assign bus.phase = phase_q;
  assign bus.wrap  = wrap_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_shift_counter.sv
// Self-checking bench: two N=4 counters (self-correcting and raw) against a
// sequence-table model, plus hand-computed expectations for directed vectors.
module tb_shift_counter;

  localparam int N    = 4;
  localparam int MASK = (1 << N) - 1;

  logic       clk = 1'b0;
  logic       init;
  logic       en;
  logic       left;
  logic       mode;
  logic       load;
  logic [3:0] lv;

  int checks   = 0;
  int failures = 0;

  shift_counter_if #(.N(N)) bus0 ();
  shift_counter_if #(.N(N)) bus1 ();

  assign bus0.en = en;
  assign bus0.left = left;
  assign bus0.mode = mode;
  assign bus0.load = load;
  assign bus0.load_val = lv;
  assign bus1.en = en;
  assign bus1.left = left;
  assign bus1.mode = mode;
  assign bus1.load = load;
  assign bus1.load_val = lv;

  shift_counter #(.N(N), .SELF_CORRECT(1'b1)) dut0 (.clk(clk), .init(init), .bus(bus0));
  shift_counter #(.N(N), .SELF_CORRECT(1'b0)) dut1 (.clk(clk), .init(init), .bus(bus1));

  always #5 clk = ~clk;

  // Model: the full sequence of each mode as a table; phase is the table index.
  int tbl_ring[N];
  int tbl_john[2*N];
  int m_q[2];
  int m_ph[2];
  bit m_wrap[2];
  bit m_err[2];
  bit m_mode[2];
  bit m_raw[2];
  bit valid = 1'b0;

  initial begin
    for (int k = 0; k < N; k++) tbl_ring[k] = 1 << k;
    tbl_john[0] = 0;
    for (int k = 1; k <= N; k++) tbl_john[k] = (1 << k) - 1;
    for (int k = N + 1; k < 2 * N; k++) tbl_john[k] = MASK & ~((1 << (k - N)) - 1);
  end

  function automatic int lookup(input int v, input bit md);
    int m;
    m = md ? 2 * N : N;
    for (int k = 0; k < m; k++) begin
      if ((md ? tbl_john[k] : tbl_ring[k]) == v) return k;
    end
    return -1;
  endfunction

  function automatic int seq_val(input bit md, input int ph);
    return md ? tbl_john[ph] : tbl_ring[ph];
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int idx;
      int m;
      if (init) begin
        m_mode[k] = mode;
        m_ph[k]   = 0;
        m_q[k]    = seq_val(mode, 0);
        m_wrap[k] = 1'b0;
        m_err[k]  = 1'b0;
        m_raw[k]  = 1'b0;
        valid     = 1'b1;
      end else if (load) begin
        m_mode[k] = mode;
        m_wrap[k] = 1'b0;
        idx = lookup(int'(lv), mode);
        if (idx >= 0) begin
          m_q[k]   = int'(lv);
          m_ph[k]  = idx;
          m_raw[k] = 1'b0;
        end else begin
          m_err[k] = 1'b1;
          m_ph[k]  = 0;
          if (k == 0) begin
            m_q[k]   = seq_val(mode, 0);
            m_raw[k] = 1'b0;
          end else begin
            m_q[k]   = int'(lv);
            m_raw[k] = 1'b1;
          end
        end
      end else if (en) begin
        m = m_mode[k] ? 2 * N : N;
        m_ph[k] = left ? (m_ph[k] + 1) % m : (m_ph[k] + m - 1) % m;
        if (!m_raw[k]) begin
          m_q[k] = seq_val(m_mode[k], m_ph[k]);
        end else if (left) begin
          m_q[k] = ((m_q[k] << 1) | (((m_q[k] >> (N - 1)) & 1) ^ int'(m_mode[k]))) & MASK;
        end else begin
          m_q[k] = (m_q[k] >> 1) | (((m_q[k] & 1) ^ int'(m_mode[k])) << (N - 1));
        end
        m_wrap[k] = (m_ph[k] == 0);
      end else begin
        m_wrap[k] = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (valid) begin
      chk("mdl_q0", 32'(bus0.q), 32'(m_q[0]));
      chk("mdl_ph0", 32'(bus0.phase), 32'(m_ph[0]));
      chk("mdl_wrap0", 32'(bus0.wrap), 32'(m_wrap[0]));
      chk("mdl_err0", 32'(bus0.err), 32'(m_err[0]));
      chk("mdl_q1", 32'(bus1.q), 32'(m_q[1]));
      chk("mdl_err1", 32'(bus1.err), 32'(m_err[1]));
      if (!m_raw[1]) begin
        chk("mdl_ph1", 32'(bus1.phase), 32'(m_ph[1]));
        chk("mdl_wrap1", 32'(bus1.wrap), 32'(m_wrap[1]));
      end
    end
  end

  task automatic cyc(input bit i, input bit e, input bit l, input bit md,
                     input bit ld, input logic [3:0] v);
    init = i;
    en   = e;
    left = l;
    mode = md;
    load = ld;
    lv   = v;
    @(posedge clk);
    @(negedge clk);
    $display("cyc init=%0b en=%0b left=%0b mode=%0b load=%0b lv=%b -> q0=%b ph0=%0d w0=%0b e0=%0b q1=%b e1=%0b",
             i, e, l, md, ld, v, bus0.q, bus0.phase, bus0.wrap, bus0.err, bus1.q, bus1.err);
  endtask

  task automatic lit(input string name, input logic [3:0] q, input logic [2:0] ph,
                     input logic w, input logic e);
    chk({name, "_q"}, 32'(bus0.q), 32'(q));
    chk({name, "_ph"}, 32'(bus0.phase), 32'(ph));
    chk({name, "_wrap"}, 32'(bus0.wrap), 32'(w));
    chk({name, "_err"}, 32'(bus0.err), 32'(e));
  endtask

  initial begin
    logic [3:0] rl_q[4]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] rr_q[4]  = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    logic [2:0] rr_ph[4] = '{3'd3, 3'd2, 3'd1, 3'd0};
    logic [3:0] jl_q[8]  = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                             4'b1110, 4'b1100, 4'b1000, 4'b0000};
    init = 1'b0; en = 1'b0; left = 1'b0; mode = 1'b0; load = 1'b0; lv = '0;

    // Ring left
    cyc(1, 0, 1, 0, 0, 4'b0000);
    lit("rst_ring", 4'b0001, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 1, 0, 0, 4'b0000);
      lit("ring_left", rl_q[i], 3'((i + 1) % 4), (i == 3), 1'b0);
    end

    // Ring right
    cyc(1, 0, 0, 0, 0, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 0, 0, 4'b0000);
      lit("ring_right", rr_q[i], rr_ph[i], (i == 3), 1'b0);
    end

    // Johnson left, mode pin toggled while running
    cyc(1, 0, 1, 1, 0, 4'b0000);
    lit("rst_john", 4'b0000, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 1, (i % 2 == 0), 0, 4'b0000);
      lit("john_left", jl_q[i], 3'((i + 1) % 8), (i == 7), 1'b0);
    end
    cyc(0, 1, 0, 0, 0, 4'b0000);
    lit("john_right1", 4'b1000, 3'd7, 1'b0, 1'b0);
    cyc(0, 1, 0, 0, 0, 4'b0000);
    lit("john_right2", 4'b1100, 3'd6, 1'b0, 1'b0);

    // Ring loads
    cyc(1, 0, 1, 0, 0, 4'b0000);
    cyc(0, 0, 1, 0, 1, 4'b0100);
    lit("ld_ring", 4'b0100, 3'd2, 1'b0, 1'b0);
    cyc(0, 0, 1, 0, 1, 4'b0110);
    lit("ld_bad_sc", 4'b0001, 3'd0, 1'b0, 1'b1);
    chk("ld_bad_raw_q", 32'(bus1.q), 32'(4'b0110));
    chk("ld_bad_raw_err", 32'(bus1.err), 32'd1);
    cyc(0, 1, 1, 0, 0, 4'b0000);
    lit("sticky1", 4'b0010, 3'd1, 1'b0, 1'b1);
    chk("raw_step_q", 32'(bus1.q), 32'(4'b1100));
    cyc(0, 1, 1, 0, 0, 4'b0000);
    lit("sticky2", 4'b0100, 3'd2, 1'b0, 1'b1);
    cyc(1, 0, 1, 0, 0, 4'b0000);
    lit("err_clr", 4'b0001, 3'd0, 1'b0, 1'b0);
    cyc(0, 0, 1, 0, 1, 4'b0000);
    lit("ld_ring_zero", 4'b0001, 3'd0, 1'b0, 1'b1);

    // Johnson loads
    cyc(1, 0, 1, 1, 0, 4'b0000);
    cyc(0, 0, 1, 1, 1, 4'b1100);
    lit("ld_john", 4'b1100, 3'd6, 1'b0, 1'b0);
    cyc(0, 0, 1, 1, 1, 4'b0111);
    lit("ld_john_low", 4'b0111, 3'd3, 1'b0, 1'b0);
    cyc(0, 0, 1, 1, 1, 4'b0101);
    lit("ld_john_bad", 4'b0000, 3'd0, 1'b0, 1'b1);
    chk("ld_john_raw_q", 32'(bus1.q), 32'(4'b0101));

    // Priority and hold
    cyc(1, 1, 1, 0, 1, 4'b1000);
    lit("prio_init", 4'b0001, 3'd0, 1'b0, 1'b0);
    cyc(0, 1, 1, 0, 1, 4'b1000);
    lit("prio_load", 4'b1000, 3'd3, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 1, 0, 4'b0000);
      lit("hold", 4'b1000, 3'd3, 1'b0, 1'b0);
    end
    cyc(0, 1, 1, 0, 0, 4'b0000);
    lit("wrap_after_load", 4'b0001, 3'd0, 1'b1, 1'b0);
    cyc(1, 1, 1, 0, 0, 4'b0000);
    lit("init_mid", 4'b0001, 3'd0, 1'b0, 1'b0);
    cyc(0, 0, 1, 0, 0, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_counter.md
Name: shift_counter

Overview:
Parametrised N-bit shift-register counter, the successor to the basic ring counter. It supports ring (one-hot) and Johnson (twisted-ring) modes, bidirectional stepping, a count enable, and parallel load with legality checking. It also reports the sequence phase, a wrap pulse and a sticky error flag. It is used as a one-hot sequencer or phase generator in sequential datapaths.

Parameters:
N, 4, register width; legal range N >= 2.
SELF_CORRECT, 1, 1 = an illegal load is replaced by the reset pattern; 0 = an illegal load is taken as-is.
PW, $clog2(2*N), phase output width (derived; not to be overridden).

Ports:
clk  input  1  clock; all state updates on the rising edge.
init  input  1  synchronous, active-high reset.
en  input  1  step enable.
left  input  1  direction: 1 = shift toward the MSB (phase +1); 0 = shift toward the LSB (phase -1).
mode  input  1  0 = ring, 1 = Johnson; sampled only on init or load.
load  input  1  parallel load strobe.
load_val  input  N  value to load.
q  output  N  counter state (registered).
phase  output  PW  index of q within its sequence (registered).
wrap  output  1  one-cycle pulse (registered).
err  output  1  sticky illegal-load flag (registered).

Behaviour:
- The single clock is clk. init is a synchronous, active-high reset. There is no asynchronous logic.
- Priority: init > load > en. With none of them asserted, all state holds and wrap = 0.
- An internal mode register, mode_q, is updated only on init or load. A change on the mode pin at any other time has no effect.
- init, one cycle later:
  - mode_q = mode.
  - q = {N-1'b0, 1'b1} in ring mode, or all zeros in Johnson mode.
  - phase = 0, wrap = 0, err = 0.
- Step (en = 1, no init or load):
  - Ring, left: q <= {q[N-2:0], q[N-1]}.
  - Ring, right: q <= {q[0], q[N-1:1]}.
  - Johnson, left: q <= {q[N-2:0], ~q[N-1]}.
  - Johnson, right: q <= {~q[0], q[N-1:1]}.
- Phase modulus M: M = N in ring mode, M = 2N in Johnson mode.
  - Left step: phase <= (phase + 1) mod M.
  - Right step: phase <= (phase == 0) ? M-1 : phase - 1.
- wrap is 1 in the cycle after a step whose next phase is 0, in either direction. wrap is 0 after init, after load, and when en = 0.
- Legality of load_val against the incoming mode:
  - Ring: exactly one bit set.
  - Johnson: the set bits are contiguous and anchored at bit 0 or at bit N-1. All-zero and all-one are both legal.
- Phase decode on a legal load:
  - Ring: phase = index of the set bit.
  - Johnson: phase = 0 if q == 0; popcount(q) if q[0] == 1; 2N - popcount(q) otherwise.
- Legal load: q = load_val, phase = decoded value, wrap = 0, err unchanged.
- Illegal load, SELF_CORRECT = 1: q = reset pattern for the loaded mode, phase = 0, err = 1.
- Illegal load, SELF_CORRECT = 0: q = load_val, phase = 0, err = 1. Stepping continues on the raw bits; phase is not meaningful until the next legal load or init.
- err is cleared only by init.
- init or load in the same cycle as en: the step is discarded.
- init mid-sequence: the counter resumes from reset on the next cycle with no residual wrap.

Decomposition:
- Package shift_counter_pkg:
  - MODE_RING = 1'b0, MODE_JOHNSON = 1'b1.
  - Function reset_pattern(mode, N).
- Sub-module shift_counter_decode: purely combinational. Inputs: value[N], mode. Outputs: legal, phase[PW]. Used for load checking; also reusable by the bench's scoreboard.
- Top level holds the state registers, the next-state multiplexer and the wrap/err logic.

Test Plan:
- Ring left, N = 4: init (mode = 0), then en = 1, left = 1 for 4 cycles -> q 0001→0010→0100→1000→0001; phase 0→1→2→3→0; wrap = 1 only in the cycle q returns to 0001.
- Ring right: init, then left = 0 for 2 cycles -> q 0001→1000→0100; phase 3, then 2; wrap = 1 after 4 steps when q = 0001.
- Johnson left: init (mode = 1), en = 1 for 8 cycles -> q 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000; phase 1..7 then 0; wrap on the 8th step. Mode pin toggled mid-run -> no effect.
- Loads, ring mode:
  - load_val = 0100 -> q = 0100, phase = 2, err = 0.
  - load_val = 0110 with SELF_CORRECT = 1 -> q = 0001, phase = 0, err = 1; err stays 1 across steps until init.
  - Johnson load of 1100 -> phase = 6.
- Priority: init = load = en = 1 -> reset pattern, phase = 0. load = en = 1 with 1000 -> q = 1000 with no step applied. en = 0 for 3 cycles -> q, phase unchanged; wrap = 0.
- SELF_CORRECT = 0 instance: load 0110 in ring mode -> q = 0110, err = 1; left step -> q = 1100.
